// File: rtl/mem_wb_stage_p.sv
// MEM/WB pipeline register with valid/ready handshake, flush, writeback
// decode (loads, R-type incl. MOVZ/MOVN, optional I-type ALU ops),
// a forwarding tap and a retired-instruction counter.
module mem_wb_stage_p #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int EN_ITYPE = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] IR,
  input  logic [DATA_W-1:0] LMD,
  input  logic [DATA_W-1:0] ALUoutput,
  input  logic              MOVZ_cond,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] o_PC,
  output logic [DATA_W-1:0] o_IR,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              reg_wen,
  output logic              fwd_valid,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] FN_MOVZ    = 6'b001010;
  localparam logic [5:0] FN_MOVN    = 6'b001011;

  // R-type writes rd; every other format names rt (or a don't-care field).
  function automatic logic [REG_AW-1:0] dec_addr(input logic [31:0] ir);
    if (ir[31:26] == OP_SPECIAL) dec_addr = REG_AW'(ir[15:11]);
    else                         dec_addr = REG_AW'(ir[20:16]);
  endfunction

  // Write enable before the register-0 suppression.
  function automatic logic dec_wen(input logic [31:0] ir, input logic movz_cond);
    logic [5:0] op;
    logic [5:0] fn;
    logic       sh0;
    op  = ir[31:26];
    fn  = ir[5:0];
    sh0 = (ir[10:6] == 5'd0);
    if (op == OP_LW)                        dec_wen = 1'b1;
    else if (op == OP_SPECIAL) begin
      if (sh0 && fn == FN_MOVZ)             dec_wen = movz_cond;
      else if (sh0 && fn == FN_MOVN)        dec_wen = !movz_cond;
      else                                  dec_wen = 1'b1;
    end
    else if (op[5:3] == 3'b001)             dec_wen = (EN_ITYPE != 0);
    else                                    dec_wen = 1'b0;
  endfunction

  logic              vld_p1;
  logic              wen_p1;
  logic [DATA_W-1:0] pc_p1;
  logic [DATA_W-1:0] ir_p1;
  logic [REG_AW-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;
  logic [CNT_W-1:0]  retired_p1;

  logic              load_p0;
  logic              consume_p0;
  logic [REG_AW-1:0] addr_p0;
  logic              wen_p0;
  logic [DATA_W-1:0] data_p0;

  assign in_ready   = !vld_p1 || out_ready;
  assign load_p0    = in_valid && in_ready && !flush;
  assign consume_p0 = vld_p1 && out_ready && !flush;
  assign addr_p0    = dec_addr(IR[31:0]);
  assign wen_p0     = dec_wen(IR[31:0], MOVZ_cond) && (addr_p0 != '0);
  assign data_p0    = (IR[31:26] == OP_LW) ? LMD : ALUoutput;

  // p0 -> p1: capture on load, retire on consume, flush drops the entry
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      vld_p1     <= 1'b0;
      wen_p1     <= 1'b0;
      pc_p1      <= '0;
      ir_p1      <= '0;
      addr_p1    <= '0;
      data_p1    <= '0;
      retired_p1 <= '0;
    end else begin
      if (flush) begin
        vld_p1 <= 1'b0;
        wen_p1 <= 1'b0;
      end else if (load_p0) begin
        vld_p1  <= 1'b1;
        wen_p1  <= wen_p0;
        pc_p1   <= PC;
        ir_p1   <= IR;
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
        wen_p1 <= 1'b0;
      end
      if (consume_p0) retired_p1 <= retired_p1 + CNT_W'(1);
    end
  end

  assign out_valid = vld_p1;
  assign reg_wen   = wen_p1;
  assign fwd_valid = wen_p1;
  assign o_PC      = pc_p1;
  assign o_IR      = ir_p1;
  assign wb_addr   = addr_p1;
  assign wb_data   = data_p1;
  assign retired   = retired_p1;

endmodule

// File: tb/tb_mem_wb_stage_p.sv
// Bench for mem_wb_stage_p: two instances (I-type enabled / 16-bit counter,
// I-type disabled / 4-bit counter) share one stimulus stream and are
// compared against a transaction-level reference model.
module tb_mem_wb_stage_p;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0, MOVZ_cond = 1'b0;
  logic [31:0] PC = '0, IR = '0, LMD = '0, ALUoutput = '0;

  logic        a_in_ready, a_out_valid, a_reg_wen, a_fwd_valid;
  logic [31:0] a_o_PC, a_o_IR, a_wb_data;
  logic [4:0]  a_wb_addr;
  logic [15:0] a_retired;
  logic        b_in_ready, b_out_valid, b_reg_wen, b_fwd_valid;
  logic [31:0] b_o_PC, b_o_IR, b_wb_data;
  logic [4:0]  b_wb_addr;
  logic [3:0]  b_retired;

  int errs = 0;
  int checks = 0;

  // Reference model state, index 0 = instance a, 1 = instance b
  logic        m_vld [2];
  logic        m_wen [2];
  logic [31:0] m_pc  [2];
  logic [31:0] m_ir  [2];
  logic [31:0] m_data[2];
  logic [4:0]  m_addr[2];
  int unsigned m_ret [2];

  always #5 clk = ~clk;

  mem_wb_stage_p #(.DATA_W(32), .REG_AW(5), .EN_ITYPE(1), .CNT_W(16)) u_a (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(a_in_ready),
    .flush(flush), .PC(PC), .IR(IR), .LMD(LMD), .ALUoutput(ALUoutput),
    .MOVZ_cond(MOVZ_cond), .out_ready(out_ready), .out_valid(a_out_valid),
    .o_PC(a_o_PC), .o_IR(a_o_IR), .wb_addr(a_wb_addr), .wb_data(a_wb_data),
    .reg_wen(a_reg_wen), .fwd_valid(a_fwd_valid), .retired(a_retired));

  mem_wb_stage_p #(.DATA_W(32), .REG_AW(5), .EN_ITYPE(0), .CNT_W(4)) u_b (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(b_in_ready),
    .flush(flush), .PC(PC), .IR(IR), .LMD(LMD), .ALUoutput(ALUoutput),
    .MOVZ_cond(MOVZ_cond), .out_ready(out_ready), .out_valid(b_out_valid),
    .o_PC(b_o_PC), .o_IR(b_o_IR), .wb_addr(b_wb_addr), .wb_data(b_wb_data),
    .reg_wen(b_reg_wen), .fwd_valid(b_fwd_valid), .retired(b_retired));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // What the writeback should be for one instruction, straight from the ISA rules
  task automatic ref_decode(input logic [31:0] ir, lmd, alu, input logic cond, input bit itype,
                            output logic [4:0] addr, output logic [31:0] data, output logic wen);
    int op, fn, sh;
    bit is_lw, is_r, is_imm;
    op = int'(ir[31:26]); fn = int'(ir[5:0]); sh = int'(ir[10:6]);
    is_lw  = (op == 35);
    is_r   = (op == 0);
    is_imm = (op >= 8 && op <= 15);
    addr = is_r ? ir[15:11] : ir[20:16];
    data = is_lw ? lmd : alu;
    if (is_lw)                    wen = 1'b1;
    else if (is_r && sh == 0 && fn == 10) wen = cond;
    else if (is_r && sh == 0 && fn == 11) wen = !cond;
    else if (is_r)                wen = 1'b1;
    else                          wen = is_imm && itype;
    if (addr == 5'd0) wen = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_vld[k] = 0; m_wen[k] = 0; m_pc[k] = 0; m_ir[k] = 0;
      m_data[k] = 0; m_addr[k] = 0; m_ret[k] = 0;
    end
  endtask

  task automatic model_step(input logic iv, fl, orr, input logic [31:0] pc, ir, lmd, alu,
                            input logic cond);
    logic [4:0]  a;
    logic [31:0] d;
    logic        w;
    for (int k = 0; k < 2; k++) begin
      bit accept;
      accept = iv && (!m_vld[k] || orr);
      if (m_vld[k] && orr && !fl) m_ret[k]++;
      if (fl) begin
        m_vld[k] = 0; m_wen[k] = 0;
      end else if (accept) begin
        ref_decode(ir, lmd, alu, cond, (k == 0), a, d, w);
        m_vld[k] = 1; m_wen[k] = w; m_pc[k] = pc; m_ir[k] = ir;
        m_addr[k] = a; m_data[k] = d;
      end else if (orr) begin
        m_vld[k] = 0; m_wen[k] = 0;
      end
    end
  endtask

  task automatic check_outs();
    chk("a_out_valid", a_out_valid, m_vld[0]);
    chk("a_reg_wen",   a_reg_wen,   m_wen[0]);
    chk("a_fwd_valid", a_fwd_valid, m_wen[0]);
    chk("a_o_PC",      a_o_PC,      m_pc[0]);
    chk("a_o_IR",      a_o_IR,      m_ir[0]);
    chk("a_wb_addr",   a_wb_addr,   m_addr[0]);
    chk("a_wb_data",   a_wb_data,   m_data[0]);
    chk("a_retired",   a_retired,   m_ret[0] % 65536);
    chk("b_out_valid", b_out_valid, m_vld[1]);
    chk("b_reg_wen",   b_reg_wen,   m_wen[1]);
    chk("b_fwd_valid", b_fwd_valid, m_wen[1]);
    chk("b_o_PC",      b_o_PC,      m_pc[1]);
    chk("b_o_IR",      b_o_IR,      m_ir[1]);
    chk("b_wb_addr",   b_wb_addr,   m_addr[1]);
    chk("b_wb_data",   b_wb_data,   m_data[1]);
    chk("b_retired",   b_retired,   m_ret[1] % 16);
  endtask

  // Drive one cycle of inputs, check in_ready before the edge and all outputs after it
  task automatic step(input logic iv, fl, orr, input logic [31:0] pc, ir, lmd, alu,
                      input logic cond);
    in_valid = iv; flush = fl; out_ready = orr; PC = pc; IR = ir;
    LMD = lmd; ALUoutput = alu; MOVZ_cond = cond;
    #1;
    chk("a_in_ready", a_in_ready, !m_vld[0] || orr);
    chk("b_in_ready", b_in_ready, !m_vld[1] || orr);
    @(posedge clk);
    model_step(iv, fl, orr, pc, ir, lmd, alu, cond);
    #1;
    check_outs();
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[31:26] = 6'd0;
      1: begin
        r[31:26] = 6'd0; r[10:6] = 5'd0;
        r[5:0] = ($urandom_range(0, 1) != 0) ? 6'h0A : 6'h0B;
      end
      2: r[31:26] = 6'd35;
      3: r[31:26] = 6'd43;
      4: r[31:26] = 6'($urandom_range(8, 15));
      5: r[31:26] = 6'd4;
      6: r[31:26] = 6'd2;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    model_reset();
    #1;
    check_outs();
    @(negedge clk) resetn = 1'b0;

    // LW, then reset asserted mid-cycle clears everything before the next edge
    step(1, 0, 1, 32'h100, 32'h8C2A0004, 32'hDEADBEEF, 32'h11111111, 0);
    chk("lw_addr", a_wb_addr, 10);
    chk("lw_data", a_wb_data, 32'hDEADBEEF);
    chk("lw_wen",  a_reg_wen, 1);
    in_valid = 0; out_ready = 0;
    #2 resetn = 1'b1;
    model_reset();
    #1;
    chk("rst_async_valid", a_out_valid, 0);
    check_outs();
    #2 resetn = 1'b0;

    step(1, 0, 1, 32'h100, 32'h8C2A0004, 32'hDEADBEEF, 32'h11111111, 0);
    chk("lw2_addr", a_wb_addr, 10);
    chk("lw2_data", a_wb_data, 32'hDEADBEEF);
    chk("lw2_valid", a_out_valid, 1);

    // MOVZ / MOVN
    step(1, 0, 1, 32'h104, 32'h0109500A, 32'h0, 32'h22, 0);
    chk("movz_c0_wen", a_reg_wen, 0);
    step(1, 0, 1, 32'h108, 32'h0109500A, 32'h0, 32'h33, 1);
    chk("movz_c1_wen", a_reg_wen, 1);
    chk("movz_c1_addr", a_wb_addr, 10);
    step(1, 0, 1, 32'h10C, 32'h0109500B, 32'h0, 32'h44, 0);
    chk("movn_c0_wen", a_reg_wen, 1);

    // Back-pressure: ADD held for 3 cycles while inputs change
    step(1, 0, 1, 32'h110, 32'h01095020, 32'h0, 32'h55, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, $urandom, rand_ir(), $urandom, $urandom, 1'($urandom));
      chk("hold_ir", a_o_IR, 32'h01095020);
      chk("hold_ready", a_in_ready, 0);
    end
    step(1, 0, 1, 32'h114, 32'h2128000C, 32'h0, 32'h66, 0);
    chk("release_ir", a_o_IR, 32'h2128000C);

    // Flush while holding a valid LW with an incoming instruction
    step(1, 0, 1, 32'h118, 32'h8C2A0004, 32'hCAFEF00D, 32'h0, 0);
    step(1, 1, 0, 32'h11C, 32'h01095020, 32'h0, 32'h77, 0);
    chk("flush_valid", a_out_valid, 0);
    chk("flush_wen", a_reg_wen, 0);
    step(1, 0, 1, 32'h120, 32'h8C2A0004, 32'h12345678, 32'h0, 0);
    step(1, 1, 1, 32'h124, 32'h01095020, 32'h0, 32'h88, 0);
    chk("flush_consume_valid", a_out_valid, 0);

    // Register 0, I-type, store
    step(1, 0, 1, 32'h128, 32'h00000000, 32'h0, 32'h99, 0);
    chk("nop_wen", a_reg_wen, 0);
    step(1, 0, 1, 32'h12C, 32'h2128000C, 32'h0, 32'hAA, 0);
    chk("addi_addr", a_wb_addr, 8);
    chk("addi_wen_a", a_reg_wen, 1);
    chk("addi_wen_b", b_reg_wen, 0);
    step(1, 0, 1, 32'h130, 32'hAC2A0004, 32'h0, 32'hBB, 0);
    chk("sw_wen", a_reg_wen, 0);

    // Counter wrap on the 4-bit instance: 17 retirements
    @(negedge clk) resetn = 1'b1;
    model_reset();
    @(negedge clk) resetn = 1'b0;
    for (int i = 0; i < 18; i++)
      step(1, 0, 1, 32'(i * 4), 32'h01095020, 32'h0, 32'(i), 0);
    chk("wrap_b", b_retired, 1);
    chk("wrap_a", a_retired, 17);

    // Randomized traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 2) != 0), $urandom, rand_ir(), $urandom, $urandom,
           1'($urandom));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage_p.md
Name: mem_wb_stage_p

Overview:
- Parametrised MEM/WB pipeline register for the five-stage MIPS datapath.
- Captures PC, IR, load data (LMD) and ALU result from the MEM stage, decodes the writeback target, and presents a registered write port to the register file.
- Adds three things the fixed-width stage does not have: a valid/ready handshake for back-pressure, a flush, and MOVN/I-type writeback decode.
- Also provides a forwarding tap and a retired-instruction counter.

Parameters:
- DATA_W, 32, width of PC, IR, LMD, ALU result and writeback data.
- REG_AW, 5, register-file address width; wb_addr is REG_AW bits.
- EN_ITYPE, 1, when 1, I-type ALU ops (opcode 001000..001111) write back rt.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk, in, 1, rising-edge clock.
- resetn, in, 1, asynchronous reset, active-high (1 = reset asserted); the port name follows the codebase; polarity is fixed as stated.
- in_valid, in, 1, MEM stage presents a valid instruction.
- in_ready, out, 1, stage can accept this cycle.
- flush, in, 1, discard held and incoming instruction.
- PC, in, DATA_W, PC of incoming instruction.
- IR, in, DATA_W, instruction word.
- LMD, in, DATA_W, load memory data.
- ALUoutput, in, DATA_W, ALU result.
- MOVZ_cond, in, 1, 1 when rt value == 0.
- out_ready, in, 1, WB/regfile consumes this cycle.
- out_valid, out, 1, held entry valid.
- o_PC, out, DATA_W, registered PC.
- o_IR, out, DATA_W, registered IR.
- wb_addr, out, REG_AW, destination register.
- wb_data, out, DATA_W, LMD for loads, else ALUoutput.
- reg_wen, out, 1, register-file write enable.
- fwd_valid, out, 1, equals reg_wen (forwarding tap).
- retired, out, CNT_W, count of consumed valid instructions.

Behaviour:
- Reset (async, resetn=1): out_valid, reg_wen, fwd_valid = 0; o_PC, o_IR, wb_addr, wb_data = 0; retired = 0. Outputs hold these values while resetn is high.
- in_ready = !out_valid || out_ready. This is combinational; there is no combinational path from in_valid to in_ready.
- Load event: in_valid && in_ready && !flush. At the next rising edge, all outputs update from the inputs and out_valid = 1. Latency is 1 cycle.
- No load and out_ready && out_valid: out_valid -> 0 and reg_wen -> 0. Data registers hold their values.
- Hold (out_valid && !out_ready): all outputs are stable, and the inputs are ignored.
- Flush (priority over load and hold):
  - At the next edge, out_valid = 0 and reg_wen = 0.
  - An incoming instruction in the same cycle is dropped.
  - retired is not incremented for the flushed entry.
- Writeback decode (op = IR[31:26], funct = IR[5:0], shamt field IR[10:6]):
  - op 100011 (LW): wb_addr = IR[20:16], wb_data = LMD, wen = 1.
  - op 000000, funct 001010 (MOVZ) with IR[10:6] = 0: wb_addr = IR[15:11], wen = MOVZ_cond.
  - op 000000, funct 001011 (MOVN) with IR[10:6] = 0: wb_addr = IR[15:11], wen = !MOVZ_cond.
  - Other op 000000: wb_addr = IR[15:11], wen = 1.
  - op 001000..001111 with EN_ITYPE = 1: wb_addr = IR[20:16], wen = 1.
  - All other cases (SW, branches, J, EN_ITYPE = 0 I-type): wen = 0; wb_addr is still set per the rt rule or 0.
  - wb_data = ALUoutput for every non-LW instruction.
  - wb_addr is fully determined for every loaded instruction; it never holds a stale value.
- Register 0: if the decoded wb_addr == 0, reg_wen = 0. This covers IR = 0 (NOP).
- reg_wen = decoded_wen && out_valid. It is registered and drops with out_valid.
- retired: increments by 1 on out_valid && out_ready && !flush, and wraps modulo 2^CNT_W.
- Simultaneous events: a consume and a load in the same cycle are legal; the new entry replaces the old one with no bubble.
- Reset mid-hold discards the entry immediately, without waiting for a clock edge.

Test Plan:
- Reset/LW: assert resetn mid-cycle → all outputs go to 0 before the next edge. Then release, IR=0x8C2A0004 (LW rt=10), LMD=0xDEADBEEF, in_valid=1, out_ready=1 → the next cycle shows wb_addr=10, wb_data=0xDEADBEEF, reg_wen=1, out_valid=1.
- MOVZ/MOVN: IR=0x0109500A with MOVZ_cond=0 → reg_wen=0. Same IR with MOVZ_cond=1 → reg_wen=1, wb_addr=10. IR=0x0109500B with MOVZ_cond=0 → reg_wen=1.
- Back-pressure: load R-type ADD (IR=0x01095020), then hold out_ready=0 for 3 cycles while changing the inputs → outputs stay constant, in_ready=0, retired stays unchanged. Raise out_ready → retired += 1, and the next instruction loads in the same edge.
- Flush: flush=1 while holding a valid LW with in_valid=1 → next cycle out_valid=0, reg_wen=0, retired unchanged.
- Reg0 / I-type:
  - IR=0 → reg_wen=0.
  - ADDI IR=0x2128000C with EN_ITYPE=1 → wb_addr=8, reg_wen=1.
  - Same ADDI with EN_ITYPE=0 → reg_wen=0.
  - SW IR=0xAC2A0004 → reg_wen=0.
- Counter wrap: with CNT_W=4, retire 17 instructions → retired = 1.
